// File: rtl/up_bus_arbiter.sv
// Two-port round-robin arbiter that serialises uP register reads/writes onto one downstream bus.
// Optional downstream-ack timeout is enabled by defining UP_ARBITER_TIMEOUT_EN.
module up_bus_arbiter #(
  parameter int ADDRESS_WIDTH  = 14,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [1:0]                 s_up_rreq,
  output logic [1:0]                 s_up_rack,
  input  logic [2*ADDRESS_WIDTH-1:0] s_up_raddr,
  output logic [63:0]                s_up_rdata,
  input  logic [1:0]                 s_up_wreq,
  output logic [1:0]                 s_up_wack,
  input  logic [2*ADDRESS_WIDTH-1:0] s_up_waddr,
  input  logic [63:0]                s_up_wdata,
  output logic                       m_up_rreq,
  input  logic                       m_up_rack,
  output logic [ADDRESS_WIDTH-1:0]   m_up_raddr,
  input  logic [31:0]                m_up_rdata,
  output logic                       m_up_wreq,
  input  logic                       m_up_wack,
  output logic [ADDRESS_WIDTH-1:0]   m_up_waddr,
  output logic [31:0]                m_up_wdata
);

  localparam int AW = ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t          state_r;
  logic            port_r;
  logic            last_grant_r;

  logic [1:0]      pend_s;
  logic            sel_s;
  logic            sel_rd_s;
  logic [AW-1:0]   sel_raddr_s;
  logic [AW-1:0]   sel_waddr_s;
  logic [31:0]     sel_wdata_s;
  logic            tmo_s;
  logic            rd_done_s;
  logic            wr_done_s;
  logic [31:0]     rd_val_s;

`ifdef UP_ARBITER_TIMEOUT_EN
  localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0]              tmo_cnt_r;

  // The count equals the number of completed wait cycles, so this fires on the last allowed one.
  assign tmo_s = (tmo_cnt_r == TMO_LAST);
`else
  assign tmo_s = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  // Grant selection: alternate ports when both pend, read ahead of write within a port.
  always_comb begin
    pend_s = s_up_rreq | s_up_wreq;
    if (pend_s == 2'b11) begin
      sel_s = ~last_grant_r;
    end else if (pend_s[0]) begin
      sel_s = 1'b0;
    end else begin
      sel_s = 1'b1;
    end
    sel_rd_s = s_up_rreq[sel_s];
    if (sel_s) begin
      sel_raddr_s = s_up_raddr[2*AW-1:AW];
      sel_waddr_s = s_up_waddr[2*AW-1:AW];
      sel_wdata_s = s_up_wdata[63:32];
    end else begin
      sel_raddr_s = s_up_raddr[AW-1:0];
      sel_waddr_s = s_up_waddr[AW-1:0];
      sel_wdata_s = s_up_wdata[31:0];
    end
    rd_done_s = m_up_rack | tmo_s;
    wr_done_s = m_up_wack | tmo_s;
    if (m_up_rack) begin
      rd_val_s = m_up_rdata;
    end else begin
      rd_val_s = 32'hDEAD_DEAD;
    end
  end

  // Transaction FSM; every bus output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      port_r       <= 1'b0;
      last_grant_r <= 1'b1;
      s_up_rack    <= 2'b00;
      s_up_wack    <= 2'b00;
      s_up_rdata   <= 64'd0;
      m_up_rreq    <= 1'b0;
      m_up_raddr   <= '0;
      m_up_wreq    <= 1'b0;
      m_up_waddr   <= '0;
      m_up_wdata   <= 32'd0;
`ifdef UP_ARBITER_TIMEOUT_EN
      tmo_cnt_r    <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|pend_s) begin
            port_r       <= sel_s;
            last_grant_r <= sel_s;
`ifdef UP_ARBITER_TIMEOUT_EN
            tmo_cnt_r    <= '0;
`endif
            if (sel_rd_s) begin
              m_up_rreq  <= 1'b1;
              m_up_raddr <= sel_raddr_s;
              state_r    <= ST_RD;
            end else begin
              m_up_wreq  <= 1'b1;
              m_up_waddr <= sel_waddr_s;
              m_up_wdata <= sel_wdata_s;
              state_r    <= ST_WR;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD: begin
          if (rd_done_s) begin
            m_up_rreq         <= 1'b0;
            s_up_rack[port_r] <= 1'b1;
            if (port_r) begin
              s_up_rdata[63:32] <= rd_val_s;
            end else begin
              s_up_rdata[31:0]  <= rd_val_s;
            end
            state_r <= ST_RESP;
          end else begin
`ifdef UP_ARBITER_TIMEOUT_EN
            tmo_cnt_r <= tmo_cnt_r + CW'(1);
`endif
            state_r <= ST_RD;
          end
        end
        ST_WR: begin
          if (wr_done_s) begin
            m_up_wreq         <= 1'b0;
            s_up_wack[port_r] <= 1'b1;
            state_r           <= ST_RESP;
          end else begin
`ifdef UP_ARBITER_TIMEOUT_EN
            tmo_cnt_r <= tmo_cnt_r + CW'(1);
`endif
            state_r <= ST_WR;
          end
        end
        ST_RESP: begin
          s_up_rack <= 2'b00;
          s_up_wack <= 2'b00;
          state_r   <= ST_IDLE;
        end
        default: begin
          m_up_rreq <= 1'b0;
          m_up_wreq <= 1'b0;
          s_up_rack <= 2'b00;
          s_up_wack <= 2'b00;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_up_bus_arbiter.sv
// Self-checking bench for up_bus_arbiter: directed scenarios plus randomized two-port traffic
// checked against a transaction-level fairness/ordering model.
module tb_up_bus_arbiter;

  localparam int AW  = 14;
  localparam int TMO = 16;

  logic          tb_data_clk = 1'b0;
  logic          rstn;
  logic [1:0]    s_up_rreq, s_up_rack, s_up_wreq, s_up_wack;
  logic [2*AW-1:0] s_up_raddr, s_up_waddr;
  logic [63:0]   s_up_rdata, s_up_wdata;
  logic          m_up_rreq, m_up_rack, m_up_wreq, m_up_wack;
  logic [AW-1:0] m_up_raddr, m_up_waddr;
  logic [31:0]   m_up_rdata, m_up_wdata;

  int vectors     = 0;
  int miscompares = 0;

  // downstream register core model
  logic        core_en   = 1'b1;
  int          ack_delay = 0;
  int          core_cnt  = 0;
  logic [31:0] core_seed = 32'h0;

  always #5 tb_data_clk = ~tb_data_clk;

  assign m_up_rack  = core_en && m_up_rreq && (core_cnt == ack_delay);
  assign m_up_wack  = core_en && m_up_wreq && (core_cnt == ack_delay);
  assign m_up_rdata = core_seed ^ {18'd0, m_up_raddr};

  always @(posedge tb_data_clk) begin
    if (m_up_rack || m_up_wack || !(m_up_rreq || m_up_wreq)) core_cnt <= 0;
    else core_cnt <= core_cnt + 1;
  end

  up_bus_arbiter #(.ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(tb_data_clk), .rstn(rstn),
    .s_up_rreq(s_up_rreq), .s_up_rack(s_up_rack), .s_up_raddr(s_up_raddr), .s_up_rdata(s_up_rdata),
    .s_up_wreq(s_up_wreq), .s_up_wack(s_up_wack), .s_up_waddr(s_up_waddr), .s_up_wdata(s_up_wdata),
    .m_up_rreq(m_up_rreq), .m_up_rack(m_up_rack), .m_up_raddr(m_up_raddr), .m_up_rdata(m_up_rdata),
    .m_up_wreq(m_up_wreq), .m_up_wack(m_up_wack), .m_up_waddr(m_up_waddr), .m_up_wdata(m_up_wdata)
  );

  task automatic tick();
    @(posedge tb_data_clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; s_up_rreq = 2'b00; s_up_wreq = 2'b00;
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_up_rreq = 2'b11; s_up_wreq = 2'b11;
    s_up_raddr = '1; s_up_waddr = '1; s_up_wdata = '1;
    tick(); tick();
    vectors++;
    if ({m_up_rreq, m_up_wreq} !== 2'b00) begin
      miscompares++; $display("FAIL reset_mreq: got %b expected 00", {m_up_rreq, m_up_wreq});
    end
    vectors++;
    if ({s_up_rack, s_up_wack} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_sack: got %b expected 0000", {s_up_rack, s_up_wack});
    end
    vectors++;
    if (s_up_rdata !== 64'd0) begin
      miscompares++; $display("FAIL reset_rdata: got %h expected 0", s_up_rdata);
    end
    vectors++;
    if ({m_up_raddr, m_up_waddr, m_up_wdata} !== 60'd0) begin
      miscompares++; $display("FAIL reset_maddr: got %h expected 0", {m_up_raddr, m_up_waddr, m_up_wdata});
    end
    s_up_rreq = 2'b00; s_up_wreq = 2'b00;
    s_up_raddr = '0; s_up_waddr = '0; s_up_wdata = '0;
    rstn = 1'b1;
  endtask

  task automatic test_single_read();
    core_seed = 32'hFEED_BABC; ack_delay = 1; core_en = 1'b1;
    s_up_raddr[AW-1:0] = 14'h2; s_up_rreq = 2'b01;
    tick();
    vectors++;
    if (m_up_rreq !== 1'b1 || m_up_raddr !== 14'h2) begin
      miscompares++; $display("FAIL single_grant: got rreq=%b raddr=%h expected 1/2", m_up_rreq, m_up_raddr);
    end
    tick();
    vectors++;
    if (s_up_rack !== 2'b00) begin
      miscompares++; $display("FAIL single_early_ack: got %b expected 00", s_up_rack);
    end
    tick();
    vectors++;
    if (s_up_rack !== 2'b01 || s_up_rdata[31:0] !== 32'hFEED_BABE || m_up_rreq !== 1'b0) begin
      miscompares++; $display("FAIL single_ack: got rack=%b rdata=%h mreq=%b expected 01/feedbabe/0",
                              s_up_rack, s_up_rdata[31:0], m_up_rreq);
    end
    tick();
    s_up_rreq = 2'b00;
    vectors++;
    if (s_up_rack !== 2'b00) begin
      miscompares++; $display("FAIL single_ack_width: got %b expected 00", s_up_rack);
    end
    tick(); tick();
  endtask

  task automatic test_alternate();
    int exp_port = 0;
    int grants = 0;
    int kcnt[2];
    logic prev_m = 1'b0;
    logic [1:0] drop_next = 2'b00;
    logic [1:0] down = 2'b00;
    int both_hi = 0;
    do_reset();
    ack_delay = 1; kcnt[0] = 0; kcnt[1] = 0;
    s_up_raddr = {14'h200, 14'h100}; s_up_rreq = 2'b11;
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick();
      if (m_up_rreq && m_up_wreq) both_hi++;
      if (m_up_rreq && !prev_m) begin
        vectors++;
        if (int'(m_up_raddr[9]) !== exp_port) begin
          miscompares++; $display("FAIL alt_order: got port %0d expected %0d (grant %0d)",
                                  m_up_raddr[9], exp_port, grants);
        end
        exp_port ^= 1;
        grants++;
      end
      prev_m = m_up_rreq;
      for (int p = 0; p < 2; p++) begin
        if (down[p] && grants < 8) begin
          kcnt[p]++;
          s_up_raddr[p*AW +: AW] = (p == 0) ? 14'h100 + 14'(kcnt[p]) : 14'h200 + 14'(kcnt[p]);
          s_up_rreq[p] = 1'b1; down[p] = 1'b0;
        end
        if (drop_next[p]) begin
          s_up_rreq[p] = 1'b0; down[p] = 1'b1; drop_next[p] = 1'b0;
        end
        if (s_up_rack[p]) drop_next[p] = 1'b1;
      end
      if (grants >= 8 && s_up_rreq == 2'b00 && !m_up_rreq && drop_next == 2'b00) break;
    end
    vectors++;
    if (grants < 8 || both_hi != 0) begin
      miscompares++; $display("FAIL alt_progress: got grants=%0d both_hi=%0d expected >=8/0", grants, both_hi);
    end
    s_up_rreq = 2'b00;
    tick(); tick();
  endtask

  task automatic test_read_then_write();
    int phase = 0;
    logic [1:0] drop = 2'b00;
    ack_delay = 0;
    s_up_raddr[AW-1:0] = 14'h5; s_up_waddr[AW-1:0] = 14'hC; s_up_wdata[31:0] = 32'hAAAA_0001;
    s_up_rreq = 2'b01; s_up_wreq = 2'b01;
    for (int cyc = 0; cyc < 40 && phase < 4; cyc++) begin
      tick();
      if (drop[0]) begin s_up_rreq = 2'b00; drop[0] = 1'b0; end
      if (drop[1]) begin s_up_wreq = 2'b00; drop[1] = 1'b0; phase = 4; end
      if (m_up_wreq && phase < 2) begin
        vectors++; miscompares++;
        $display("FAIL rw_order: got write grant in phase %0d expected read first", phase);
        phase = 2;
      end
      if (phase == 0 && m_up_rreq) begin
        vectors++;
        if (m_up_raddr !== 14'h5) begin
          miscompares++; $display("FAIL rw_raddr: got %h expected 5", m_up_raddr);
        end
        phase = 1;
      end else if (phase == 1 && s_up_rack == 2'b01) begin
        drop[0] = 1'b1; phase = 2;
      end else if (phase == 2 && m_up_wreq) begin
        vectors++;
        if (m_up_waddr !== 14'hC || m_up_wdata !== 32'hAAAA_0001 || m_up_rreq !== 1'b0) begin
          miscompares++; $display("FAIL rw_write: got waddr=%h wdata=%h rreq=%b expected c/aaaa0001/0",
                                  m_up_waddr, m_up_wdata, m_up_rreq);
        end
        phase = 3;
      end else if (phase == 3 && s_up_wack != 2'b00) begin
        vectors++;
        if (s_up_wack !== 2'b01) begin
          miscompares++; $display("FAIL rw_wack: got %b expected 01", s_up_wack);
        end
        drop[1] = 1'b1;
      end
    end
    vectors++;
    if (phase != 4) begin
      miscompares++; $display("FAIL rw_timeout: got phase %0d expected 4", phase);
    end
    s_up_rreq = 2'b00; s_up_wreq = 2'b00;
    tick(); tick();
  endtask

  task automatic test_slow_ack();
    int hi = 0;
    int acks = 0;
    logic drop = 1'b0;
    core_seed = 32'h1357_9BDF; ack_delay = 10;
    s_up_raddr[2*AW-1:AW] = 14'h3A; s_up_rreq = 2'b10;
    for (int cyc = 0; cyc < 60; cyc++) begin
      tick();
      if (drop) begin s_up_rreq = 2'b00; drop = 1'b0; end
      if (m_up_rreq) begin
        hi++;
        vectors++;
        if (m_up_raddr !== 14'h3A) begin
          miscompares++; $display("FAIL slow_addr_stable: got %h expected 3a", m_up_raddr);
        end
      end
      if (s_up_rack != 2'b00) begin
        acks++;
        vectors++;
        if (s_up_rack !== 2'b10 || s_up_rdata[63:32] !== (32'h1357_9BDF ^ 32'h3A)) begin
          miscompares++; $display("FAIL slow_ack: got rack=%b rdata=%h expected 10/%h",
                                  s_up_rack, s_up_rdata[63:32], 32'h1357_9BDF ^ 32'h3A);
        end
        drop = 1'b1;
      end
    end
    vectors++;
    if (hi < 10 || acks != 1) begin
      miscompares++; $display("FAIL slow_count: got hi=%0d acks=%0d expected >=10/1", hi, acks);
    end
    ack_delay = 0;
  endtask

  task automatic test_reset_mid();
    int regrant = 0;
    int acks = 0;
    logic drop = 1'b0;
    core_en = 1'b0; core_seed = 32'h0BAD_F00D;
    s_up_raddr[AW-1:0] = 14'h11; s_up_rreq = 2'b01;
    tick(); tick(); tick(); tick();
    vectors++;
    if (m_up_rreq !== 1'b1) begin
      miscompares++; $display("FAIL mid_in_rd: got rreq=%b expected 1", m_up_rreq);
    end
    rstn = 1'b0;
    tick();
    vectors++;
    if ({m_up_rreq, m_up_wreq, s_up_rack, s_up_wack} !== 6'd0 || s_up_rdata !== 64'd0 || m_up_raddr !== 14'd0) begin
      miscompares++; $display("FAIL mid_reset_outputs: got mreq=%b sack=%b rdata=%h raddr=%h expected all 0",
                              {m_up_rreq, m_up_wreq}, {s_up_rack, s_up_wack}, s_up_rdata, m_up_raddr);
    end
    rstn = 1'b1; core_en = 1'b1; ack_delay = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (drop) begin s_up_rreq = 2'b00; drop = 1'b0; end
      if (m_up_rreq && m_up_raddr == 14'h11) regrant++;
      if (s_up_rack != 2'b00) begin
        acks++;
        vectors++;
        if (s_up_rack !== 2'b01 || s_up_rdata[31:0] !== (32'h0BAD_F00D ^ 32'h11)) begin
          miscompares++; $display("FAIL mid_ack: got rack=%b rdata=%h expected 01/%h",
                                  s_up_rack, s_up_rdata[31:0], 32'h0BAD_F00D ^ 32'h11);
        end
        drop = 1'b1;
      end
    end
    vectors++;
    if (regrant != 1 || acks != 1) begin
      miscompares++; $display("FAIL mid_regrant: got regrant=%0d acks=%0d expected 1/1", regrant, acks);
    end
  endtask

  task automatic test_timeout();
    int hi = 0;
    int acks = 0;
    core_en = 1'b0;
    s_up_raddr[AW-1:0] = 14'h7; s_up_rreq = 2'b01;
`ifdef UP_ARBITER_TIMEOUT_EN
    for (int cyc = 0; cyc < 100 && acks == 0; cyc++) begin
      tick();
      if (m_up_rreq) hi++;
      if (s_up_rack != 2'b00) begin
        acks++;
        vectors++;
        if (s_up_rack !== 2'b01 || s_up_rdata[31:0] !== 32'hDEAD_DEAD || hi != TMO) begin
          miscompares++; $display("FAIL tmo_ack: got rack=%b rdata=%h rd_cycles=%0d expected 01/deaddead/%0d",
                                  s_up_rack, s_up_rdata[31:0], hi, TMO);
        end
      end
    end
    tick();
    s_up_rreq = 2'b00;
    vectors++;
    if (acks != 1) begin
      miscompares++; $display("FAIL tmo_no_ack: got acks=%0d expected 1", acks);
    end
    core_en = 1'b1;
    tick(); tick();
`else
    for (int cyc = 0; cyc < 100; cyc++) begin
      tick();
      if (m_up_rreq) hi++;
      if (s_up_rack != 2'b00) acks++;
    end
    vectors++;
    if (acks != 0 || hi < 98) begin
      miscompares++; $display("FAIL wait_forever: got acks=%0d rd_cycles=%0d expected 0/>=98", acks, hi);
    end
    core_en = 1'b1;
    do_reset();
`endif
  endtask

  task automatic test_back_to_back_random();
    localparam int N = 40;
    logic       busy[2];
    logic       cur_wr[2];
    logic [13:0] cur_addr[2];
    logic [31:0] cur_data[2];
    logic [31:0] exp_rdata[2];
    int issued[2], done[2], gap[2];
    logic [1:0] drop_next = 2'b00;
    logic [1:0] prev_pend = 2'b00;
    logic prev_m = 1'b0;
    int model_last = 1;
    int inflight = -1;
    int exp_p;
    do_reset();
    core_seed = $urandom;
    for (int p = 0; p < 2; p++) begin
      busy[p] = 1'b0; issued[p] = 0; done[p] = 0; gap[p] = 0; exp_rdata[p] = 32'd0;
      cur_wr[p] = 1'b0; cur_addr[p] = 14'd0; cur_data[p] = 32'd0;
    end
    for (int cyc = 0; cyc < 3000 && (done[0] + done[1]) < 2 * N; cyc++) begin
      tick();
      if (m_up_rreq && m_up_wreq) begin
        vectors++; miscompares++; $display("FAIL rnd_both_mreq: got rreq=1 wreq=1 expected exclusive");
      end
      if ((m_up_rreq || m_up_wreq) && !prev_m) begin
        if (prev_pend == 2'b11) exp_p = 1 - model_last;
        else exp_p = prev_pend[0] ? 0 : 1;
        vectors++;
        if (prev_pend == 2'b00 || inflight != -1) begin
          miscompares++; $display("FAIL rnd_spurious_grant: got pend=%b inflight=%0d expected pending and idle",
                                  prev_pend, inflight);
        end else if (m_up_wreq !== cur_wr[exp_p] ||
                     (cur_wr[exp_p] && (m_up_waddr !== cur_addr[exp_p] || m_up_wdata !== cur_data[exp_p])) ||
                     (!cur_wr[exp_p] && m_up_raddr !== cur_addr[exp_p])) begin
          miscompares++; $display("FAIL rnd_grant: got wr=%b raddr=%h waddr=%h wdata=%h expected port%0d wr=%b addr=%h data=%h",
                                  m_up_wreq, m_up_raddr, m_up_waddr, m_up_wdata, exp_p,
                                  cur_wr[exp_p], cur_addr[exp_p], cur_data[exp_p]);
        end
        inflight = exp_p; model_last = exp_p;
        ack_delay = $urandom_range(0, 3);
      end
      prev_m = m_up_rreq || m_up_wreq;
      for (int p = 0; p < 2; p++) begin
        if (s_up_rack[p] || s_up_wack[p]) begin
          vectors++;
          if (!cur_wr[p]) exp_rdata[p] = core_seed ^ {18'd0, cur_addr[p]};
          if (inflight != p || s_up_wack[p] !== cur_wr[p] || s_up_rack[p] === cur_wr[p] ||
              s_up_rdata !== {exp_rdata[1], exp_rdata[0]}) begin
            miscompares++; $display("FAIL rnd_ack: got port%0d rack=%b wack=%b rdata=%h expected inflight=%0d wr=%b rdata=%h",
                                    p, s_up_rack, s_up_wack, s_up_rdata, inflight, cur_wr[p],
                                    {exp_rdata[1], exp_rdata[0]});
          end
          inflight = -1; done[p]++; drop_next[p] = 1'b1;
        end else if (drop_next[p]) begin
          s_up_rreq[p] = 1'b0; s_up_wreq[p] = 1'b0; busy[p] = 1'b0; drop_next[p] = 1'b0;
          gap[p] = $urandom_range(0, 2);
        end else if (!busy[p] && issued[p] < N) begin
          if (gap[p] > 0) gap[p]--;
          else begin
            cur_wr[p] = 1'($urandom_range(0, 1)); cur_addr[p] = 14'($urandom); cur_data[p] = $urandom;
            if (cur_wr[p]) begin
              s_up_waddr[p*AW +: AW] = cur_addr[p]; s_up_wdata[p*32 +: 32] = cur_data[p]; s_up_wreq[p] = 1'b1;
            end else begin
              s_up_raddr[p*AW +: AW] = cur_addr[p]; s_up_rreq[p] = 1'b1;
            end
            busy[p] = 1'b1; issued[p]++;
          end
        end
      end
      prev_pend = s_up_rreq | s_up_wreq;
    end
    vectors++;
    if (done[0] != N || done[1] != N) begin
      miscompares++; $display("FAIL rnd_complete: got done=%0d/%0d expected %0d/%0d", done[0], done[1], N, N);
    end
    tick();
    s_up_rreq = 2'b00; s_up_wreq = 2'b00;
    tick(); tick();
  endtask

  initial begin
    rstn = 1'b0; s_up_rreq = 2'b00; s_up_wreq = 2'b00;
    s_up_raddr = '0; s_up_waddr = '0; s_up_wdata = '0;
    test_reset();
    test_single_read();
    test_alternate();
    test_read_then_write();
    test_slow_ack();
    test_reset_mid();
    test_timeout();
    test_back_to_back_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
